operand_loader: RTL
===================

# operand_loader

Upstream feeder for `tile_processor`. Accepts a byte stream with a valid/ready handshake, decodes a two-byte header (op code, tile coordinates), and writes the operand payload into SRAM_A and then SRAM_B starting at address 0. It then pulses `tile_start` with stable `op_code`/`tile_i`/`tile_j`, and waits for `tile_done` before accepting the next frame. It owns the A/B write ports while loading; `tile_processor` reads them afterwards.

## Interface
- `ADDR_W`, 10, SRAM address width
- `DATA_W`, 8, SRAM/stream data width
- `TIMEOUT_CYC`, 4096, max cycles in WAIT before error
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `s_valid`  in  1  stream byte valid
- `s_data`  in  DATA_W  stream byte
- `s_ready`  out  1  loader accepts byte
- `ld_sram_A_ce`, `ld_sram_A_we`  out  1  SRAM_A chip enable / write enable
- `ld_sram_A_addr`  out  ADDR_W  SRAM_A address
- `ld_sram_A_din`  out  DATA_W  SRAM_A write data
- `ld_sram_B_ce`, `ld_sram_B_we`, `ld_sram_B_addr`, `ld_sram_B_din`: same as A, for SRAM_B
- `op_code`  out  3  operation for tile_processor
- `tile_i`, `tile_j`  out  3  tile coordinates
- `tile_start`  out  1  one-cycle start pulse
- `tile_done`  in  1  tile_processor done (level)
- `busy`  out  1  state != HDR0
- `err`  out  1  one-cycle error pulse

## Operation
- Frame format:
  - byte0 = {op_code[2:0], tile_i[2:0], 2'b00}
  - byte1 = {tile_j[2:0], 5'b0}
  - then LEN_A bytes for A, then LEN_B bytes for B.
- Lengths by op: ADD(1) 16/16, SUB(2) 16/16, CONV(3) 36/9, DOT(4) 16/16.
- States: HDR0 → HDR1 → LOAD_A → LOAD_B → SETTLE → ISSUE → WAIT → HDR0.
- Transfer occurs when `s_valid && s_ready`. `s_ready`=1 in HDR0, HDR1, LOAD_A and LOAD_B; 0 otherwise.
- HDR0 handshake:
  - op in 1..4: latch op_code and tile_i, go to HDR1.
  - op 0 or 5..7: pulse `err`, stay in HDR0, keep previous op_code/tile outputs. The byte is consumed.
- HDR1 handshake: latch tile_j, clear byte counter `cnt` (6 bits), go to LOAD_A. Low 5 bits of byte1 are ignored.
- LOAD_A handshake:
  - Registered write next cycle: ce=we=1, addr=cnt (zero-extended), din=byte.
  - `cnt`++. On byte LEN_A−1: clear `cnt`, go to LOAD_B.
- LOAD_B: same writes to SRAM_B. On byte LEN_B−1 go to SETTLE.
- SETTLE: one cycle; last B write is driven on the outputs.
- ISSUE: `tile_start`=1 for this single cycle; go to WAIT.
- WAIT:
  - Wait counter starts at 0 and increments each cycle.
  - `tile_done`=1 sampled → HDR0.
  - Counter reaches TIMEOUT_CYC−1 → `err` pulse, HDR0.
- `tile_done` is ignored in every state except WAIT.
- op_code, tile_i and tile_j are registered and held stable from header capture until the next valid header.
- Gaps (`s_valid`=0) mid-frame stall without limit. No timeout while loading.

## Timing
- Reset values: `s_ready`=1 (state HDR0); all ce/we/addr/din, op_code, tile_i, tile_j, `tile_start`, `err` and `busy` are 0.
- Write latency: byte accepted at edge k → ce/we/addr/din valid from edge k to edge k+1 → SRAM writes at k+1.
- Outside an accepted-byte cycle, ce/we are 0. addr/din hold their last value.
- Full-rate stream: LEN_A+LEN_B+2 handshake cycles. The last B byte is accepted at edge k:
  - SETTLE spans k..k+1
  - `tile_start` is high k+1..k+2
  - earliest `tile_done` sample is at k+3.
- Frame-to-frame: `s_ready` rises the cycle after `tile_done` is sampled high.
- Asynchronous `rst` mid-frame: immediate return to HDR0 with all outputs at reset values. Bytes already written stay in the SRAMs. The next byte is treated as byte0.
- A/B ports are never enabled in the same cycle.

## Structure
- Shared package `npu_pkg`:
  - `op_e` enum: OP_NOP=0, OP_ADD=1, OP_SUB=2, OP_CONV=3, OP_DOT=4
  - `ld_state_e`
  - localparams LEN_A/LEN_B per op, plus a function `op_len_a(op)`/`op_len_b(op)`
  - `op_valid(op)`
- Single module, no sub-module. The wait counter is sized `$clog2(TIMEOUT_CYC)`.

## Test plan
- ADD frame 0x20,0x00, 16×0x01, 16×0x02 at full rate → SRAM_A[0..15]=01, SRAM_B[0..15]=02, one `tile_start` pulse with op_code=1, tile_i=tile_j=0.
- CONV frame 0x60,0x00 (op3), 36×0x01, 9×0x01 with random `s_valid` gaps → 36 A writes (addr 0..35), 9 B writes (addr 0..8), `tile_start` exactly 2 cycles after the last B accept, `s_ready`=0 until `tile_done`.
- Header 0x00 then 0xE0 → two `err` pulses, state stays HDR0, no SRAM writes, op_code unchanged.
- DOT frame with `tile_done` held 0 → `err` pulse at TIMEOUT_CYC cycles into WAIT, `s_ready`=1 next cycle.
- Assert `rst` after 10 A bytes → all outputs 0 immediately. A following valid ADD frame loads correctly from addr 0.
- `tile_done`=1 while in HDR0/LOAD_A → ignored. After `tile_start`, `tile_done` pulsed at +5 cycles → return to HDR0 on that edge.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared NPU types: op codes, loader states, per-op operand lengths and header helpers.
package npu_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_CONV = 3'd3,
    OP_DOT  = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    LD_HDR0   = 3'd0,
    LD_HDR1   = 3'd1,
    LD_LOAD_A = 3'd2,
    LD_LOAD_B = 3'd3,
    LD_SETTLE = 3'd4,
    LD_ISSUE  = 3'd5,
    LD_WAIT   = 3'd6
  } ld_state_e;

  localparam logic [5:0] LEN_A_STD  = 6'd16;
  localparam logic [5:0] LEN_B_STD  = 6'd16;
  localparam logic [5:0] LEN_A_CONV = 6'd36;
  localparam logic [5:0] LEN_B_CONV = 6'd9;

  function automatic logic [5:0] op_len_a(input logic [2:0] op);
    return (op == OP_CONV) ? LEN_A_CONV : LEN_A_STD;
  endfunction

  function automatic logic [5:0] op_len_b(input logic [2:0] op);
    return (op == OP_CONV) ? LEN_B_CONV : LEN_B_STD;
  endfunction

  function automatic logic op_valid(input logic [2:0] op);
    return (op >= OP_ADD) && (op <= OP_DOT);
  endfunction

endpackage

// File: rtl/operand_loader.sv
// Decodes a framed byte stream into SRAM_A/SRAM_B writes (registered, 1 cycle) and issues one tile.
// s_ready drops from the last payload byte until tile_done or the WAIT timeout returns it to HDR0.
module operand_loader
  import npu_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              ld_sram_A_ce,
  output logic              ld_sram_A_we,
  output logic [ADDR_W-1:0] ld_sram_A_addr,
  output logic [DATA_W-1:0] ld_sram_A_din,
  output logic              ld_sram_B_ce,
  output logic              ld_sram_B_we,
  output logic [ADDR_W-1:0] ld_sram_B_addr,
  output logic [DATA_W-1:0] ld_sram_B_din,
  output logic [2:0]        op_code,
  output logic [2:0]        tile_i,
  output logic [2:0]        tile_j,
  output logic              tile_start,
  input  logic              tile_done,
  output logic              busy,
  output logic              err
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYC);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

  localparam logic [2:0] S_HDR0   = LD_HDR0;
  localparam logic [2:0] S_HDR1   = LD_HDR1;
  localparam logic [2:0] S_LOAD_A = LD_LOAD_A;
  localparam logic [2:0] S_LOAD_B = LD_LOAD_B;
  localparam logic [2:0] S_SETTLE = LD_SETTLE;
  localparam logic [2:0] S_ISSUE  = LD_ISSUE;
  localparam logic [2:0] S_WAIT   = LD_WAIT;

  logic [2:0]        state;
  logic [5:0]        cnt;
  logic [WAIT_W-1:0] wcnt;
  logic              xfer;
  logic [2:0]        hdr_op, hdr_ti, hdr_tj;
  logic              last_a, last_b;

  // Header fields: byte0 = {op, tile_i, 2'b00}, byte1 = {tile_j, 5'b0}; reserved bits dropped.
  assign hdr_op = s_data[7:5];
  assign hdr_ti = s_data[4:2];
  assign hdr_tj = s_data[7:5];

  assign s_ready = (state == S_HDR0) || (state == S_HDR1) ||
                   (state == S_LOAD_A) || (state == S_LOAD_B);
  assign busy    = (state != S_HDR0);
  assign xfer    = s_valid && s_ready;
  assign last_a  = (cnt == op_len_a(op_code) - 6'd1);
  assign last_b  = (cnt == op_len_b(op_code) - 6'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_HDR0;
      cnt            <= '0;
      wcnt           <= '0;
      ld_sram_A_ce   <= 1'b0;
      ld_sram_A_we   <= 1'b0;
      ld_sram_A_addr <= '0;
      ld_sram_A_din  <= '0;
      ld_sram_B_ce   <= 1'b0;
      ld_sram_B_we   <= 1'b0;
      ld_sram_B_addr <= '0;
      ld_sram_B_din  <= '0;
      op_code        <= '0;
      tile_i         <= '0;
      tile_j         <= '0;
      tile_start     <= 1'b0;
      err            <= 1'b0;
    end else begin
      ld_sram_A_ce <= 1'b0;
      ld_sram_A_we <= 1'b0;
      ld_sram_B_ce <= 1'b0;
      ld_sram_B_we <= 1'b0;
      tile_start   <= 1'b0;
      err          <= 1'b0;
      case (state)
        S_HDR0: begin
          if (xfer) begin
            if (op_valid(hdr_op)) begin
              op_code <= hdr_op;
              tile_i  <= hdr_ti;
              state   <= S_HDR1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_HDR1: begin
          if (xfer) begin
            tile_j <= hdr_tj;
            cnt    <= '0;
            state  <= S_LOAD_A;
          end
        end
        S_LOAD_A: begin
          if (xfer) begin
            ld_sram_A_ce   <= 1'b1;
            ld_sram_A_we   <= 1'b1;
            ld_sram_A_addr <= ADDR_W'(cnt);
            ld_sram_A_din  <= s_data;
            if (last_a) begin
              cnt   <= '0;
              state <= S_LOAD_B;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
        S_LOAD_B: begin
          if (xfer) begin
            ld_sram_B_ce   <= 1'b1;
            ld_sram_B_we   <= 1'b1;
            ld_sram_B_addr <= ADDR_W'(cnt);
            ld_sram_B_din  <= s_data;
            if (last_b) begin
              cnt   <= '0;
              state <= S_SETTLE;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
        // Last B write is on the port this cycle; start is registered so it lands one cycle later.
        S_SETTLE: begin
          tile_start <= 1'b1;
          state      <= S_ISSUE;
        end
        S_ISSUE: begin
          wcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (tile_done) begin
            state <= S_HDR0;
          end else if (wcnt == WAIT_LAST) begin
            err   <= 1'b1;
            state <= S_HDR0;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        default: state <= S_HDR0;
      endcase
    end
  end

endmodule
